// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_pkg
// Purpose  : Shared types for the instruction-fetch stage: FSM state
//            encodings, the default-width prefetch-queue entry and a helper
//            that widens the state to the 3-bit debug port.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    localparam int unsigned c_DEF_AW   = 16;
    localparam int unsigned c_DEF_IW   = 32;
    localparam int unsigned c_ESTADO_W = 3;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_FETCH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Queue entry at the default widths; the fetch stage declares the same
    // layout locally so that it follows its own AW/IW parameters.
    typedef struct packed {
        logic [c_DEF_IW-1:0] instr;
        logic [c_DEF_AW-1:0] npc;
    } fq_entry_t;

    function automatic logic [c_ESTADO_W-1:0] estado_of(input state_t s);
        return {1'b0, s};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_q_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Synchronous FIFO with flush, occupancy count and combinational
//            head read (reads zero when empty).
// Ports    : clk_i, rst_i   - clock, synchronous active-high reset
//            flush_i        - empties the queue; cancels push/pop this cycle
//            push_i/wdata_i - write request and data
//            pop_i          - remove head (ignored when empty)
//            rdata_o        - head entry, zero when empty
//            count_o        - number of valid entries
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned c_PW = $clog2(DEPTH);
    localparam int unsigned c_CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_PW-1:0]  rd_ptr_q;
    logic [c_PW-1:0]  wr_ptr_q;
    logic [c_CW-1:0]  count_q;
    logic             w_push;
    logic             w_pop;

    assign w_push = push_i & ~flush_i;
    assign w_pop  = pop_i & ~flush_i & (count_q != '0);

    // DEPTH is a power of two, so pointer increments wrap by themselves.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + c_PW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PW'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CW'(1);
                2'b01:   count_q <= count_q - c_CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_q.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_q
// Purpose  : Instruction-fetch stage. One outstanding req/ack transaction to
//            instruction memory, DEPTH-entry prefetch queue toward decode,
//            branch redirect with flush.
// Ports    : CLK, RST          - clock, synchronous active-high reset
//            COND, ULA         - taken-branch strobe and target
//            MEM_REQ/MEM_ADDR  - memory request and fetch address
//            MEM_ACK/MEM_OUT   - memory acknowledge and instruction data
//            IR, NPC, IR_VALID - head instruction, its address + PC_INC
//            IR_READY          - decode accepts the head
//            ESTADO            - current FSM state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_q
    import inst_fetch_pkg::*;
#(
    parameter int unsigned   AW       = c_DEF_AW,
    parameter int unsigned   IW       = c_DEF_IW,
    parameter int unsigned   DEPTH    = 4,
    parameter int unsigned   PC_INC   = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  COND,
    input  logic [AW-1:0]         ULA,
    output logic                  MEM_REQ,
    output logic [AW-1:0]         MEM_ADDR,
    input  logic                  MEM_ACK,
    input  logic [IW-1:0]         MEM_OUT,
    output logic [IW-1:0]         IR,
    output logic [AW-1:0]         NPC,
    output logic                  IR_VALID,
    input  logic                  IR_READY,
    output logic [c_ESTADO_W-1:0] ESTADO
);

    localparam int unsigned c_CW = $clog2(DEPTH+1);
    localparam int unsigned c_EW = IW + AW;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] npc;
    } entry_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   tgt_q, tgt_d;
    logic            req_q, req_d;

    logic [AW-1:0]   w_pc_inc;
    logic [AW-1:0]   w_target;
    logic            w_push;
    logic            w_pop;
    logic [c_CW-1:0] w_count;
    logic [c_CW-1:0] w_count_after;
    logic            w_room;
    entry_t          w_wr_entry;
    entry_t          w_head;

    assign w_pc_inc = pc_q + AW'(PC_INC);
    // Only S_DRAIN uses this: a fresh COND overrides the latched target.
    assign w_target = COND ? ULA : tgt_q;

    // Data acknowledged together with a redirect is stale and never queued.
    assign w_push = (state_q == S_FETCH) & MEM_ACK & ~COND;
    assign w_pop  = IR_VALID & IR_READY;

    // Occupancy after this edge decides whether another request may start,
    // which keeps every outstanding request guaranteed a free slot.
    assign w_count_after = w_count + {{(c_CW-1){1'b0}}, w_push}
                                   - {{(c_CW-1){1'b0}}, w_pop};
    assign w_room        = (w_count_after < c_CW'(DEPTH));

    assign w_wr_entry.instr = MEM_OUT;
    assign w_wr_entry.npc   = w_pc_inc;

    fetch_queue #(
        .WIDTH (c_EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i   (CLK),
        .rst_i   (RST),
        .flush_i (COND),
        .push_i  (w_push),
        .wdata_i (w_wr_entry),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .count_o (w_count)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_INIT;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            tgt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        tgt_d   = tgt_q;
        req_d   = req_q;
        case (state_q)
            S_INIT, S_IDLE: begin
                if (COND) begin
                    pc_d    = ULA;
                    addr_d  = ULA;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else if ((state_q == S_INIT) || w_room) begin
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (COND && MEM_ACK) begin
                    pc_d   = ULA;
                    addr_d = ULA;
                end else if (COND) begin
                    // Request still in flight: finish it before redirecting.
                    tgt_d   = ULA;
                    state_d = S_DRAIN;
                end else if (MEM_ACK) begin
                    pc_d = w_pc_inc;
                    if (w_room) begin
                        addr_d = w_pc_inc;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                tgt_d = w_target;
                if (MEM_ACK) begin
                    pc_d    = w_target;
                    addr_d  = w_target;
                    state_d = S_FETCH;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_INIT;
            end
        endcase
    end

    assign MEM_REQ  = req_q;
    assign MEM_ADDR = addr_q;
    assign IR       = w_head.instr;
    assign NPC      = w_head.npc;
    assign IR_VALID = (w_count != '0);
    assign ESTADO   = estado_of(state_q);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_q.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_q
// Purpose  : Self-checking bench for inst_fetch_q. A transaction-level model
//            (queue of expected {instr, npc}, expected request address,
//            pending-redirect flag) is checked every cycle; directed steps
//            add explicit checks for latency, wait states, backpressure,
//            redirects, reset and address wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_q;

    localparam int unsigned AW     = 16;
    localparam int unsigned IW     = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PC_INC = 4;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] npc;
    } ent_t;

    logic          CLK = 1'b0;
    logic          RST, COND, MEM_ACK, IR_READY;
    logic [AW-1:0] ULA;
    logic [IW-1:0] MEM_OUT;

    logic          MEM_REQ, IR_VALID, b_MEM_REQ, b_IR_VALID;
    logic [AW-1:0] MEM_ADDR, NPC, b_MEM_ADDR, b_NPC;
    logic [IW-1:0] IR, b_IR;
    logic [2:0]    ESTADO, b_ESTADO;

    inst_fetch_q #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .PC_INC(PC_INC),
                   .RESET_PC(16'h0000)) u_dut (
        .CLK(CLK), .RST(RST), .COND(COND), .ULA(ULA),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK),
        .MEM_OUT(MEM_OUT), .IR(IR), .NPC(NPC), .IR_VALID(IR_VALID),
        .IR_READY(IR_READY), .ESTADO(ESTADO)
    );

    // Second instance only to observe the address wrap from 0xFFFC.
    inst_fetch_q #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .PC_INC(PC_INC),
                   .RESET_PC(16'hFFFC)) u_dut_wrap (
        .CLK(CLK), .RST(RST), .COND(COND), .ULA(ULA),
        .MEM_REQ(b_MEM_REQ), .MEM_ADDR(b_MEM_ADDR), .MEM_ACK(MEM_ACK),
        .MEM_OUT(MEM_OUT), .IR(b_IR), .NPC(b_NPC), .IR_VALID(b_IR_VALID),
        .IR_READY(IR_READY), .ESTADO(b_ESTADO)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model state
    ent_t          mq[$];
    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_tgt;
    bit            m_drain;
    int            starve;
    int            n_acks;

    // Memory responder state
    int rc;
    int cur_wait;
    int fixed_wait;
    bit rand_mode;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model checks at the falling edge, model update for the
    // coming rising edge, then memory response driven #1 after that edge.
    task automatic cycle();
        bit            ack;
        bit            req_before;
        logic [IW-1:0] exp_ir;
        logic [AW-1:0] exp_npc;
        ent_t          e;
        @(negedge CLK);
        req_before = (MEM_REQ === 1'b1);
        ack        = req_before && (MEM_ACK === 1'b1);
        if (RST) begin
            mq.delete();
            m_addr  = 16'h0000;
            m_drain = 1'b0;
            starve  = 0;
        end else begin
            exp_ir  = '0;
            exp_npc = '0;
            if (mq.size() != 0) begin
                exp_ir  = mq[0].instr;
                exp_npc = mq[0].npc;
            end
            chk("ir_valid", 64'(IR_VALID), 64'(mq.size() != 0));
            chk("ir", 64'(IR), 64'(exp_ir));
            chk("npc", 64'(NPC), 64'(exp_npc));
            if (MEM_REQ) begin
                chk("mem_addr", 64'(MEM_ADDR), 64'(m_addr));
                chk("issue_room", 64'(mq.size() < DEPTH), 64'd1);
            end
            starve = (!MEM_REQ && mq.size() < DEPTH) ? starve + 1 : 0;
            chk("fetch_stall", 64'(starve > 2), 64'd0);
            if (ack) n_acks++;
            if (COND) begin
                mq.delete();
                if (!req_before || ack) begin
                    m_addr  = ULA;
                    m_drain = 1'b0;
                end else begin
                    m_drain = 1'b1;
                    m_tgt   = ULA;
                end
            end else begin
                if ((mq.size() != 0) && IR_READY) void'(mq.pop_front());
                if (ack) begin
                    if (m_drain) begin
                        m_addr  = m_tgt;
                        m_drain = 1'b0;
                    end else begin
                        e.instr = MEM_OUT;
                        e.npc   = m_addr + 16'(PC_INC);
                        mq.push_back(e);
                        m_addr  = m_addr + 16'(PC_INC);
                    end
                end
            end
        end
        @(posedge CLK);
        #1;
        rc = (MEM_REQ && req_before && !ack) ? rc + 1 : 0;
        if (rc == 0) cur_wait = rand_mode ? int'($urandom_range(0, 3)) : fixed_wait;
        MEM_ACK = MEM_REQ && (rc >= cur_wait);
        MEM_OUT = rand_mode ? IW'($urandom) : IW'(MEM_ADDR >> 2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   64'(MEM_REQ),    64'd0);
        chk({tag, "_addr"},  64'(MEM_ADDR),   64'd0);
        chk({tag, "_ir"},    64'(IR),         64'd0);
        chk({tag, "_npc"},   64'(NPC),        64'd0);
        chk({tag, "_valid"}, 64'(IR_VALID),   64'd0);
        chk({tag, "_state"}, 64'(ESTADO),     64'd0);
        chk({tag, "_waddr"}, 64'(b_MEM_ADDR), 64'd0);
    endtask

    initial begin
        int  vcount;
        bit  found;
        RST = 1'b1; COND = 1'b0; ULA = '0; MEM_ACK = 1'b0; MEM_OUT = '0;
        IR_READY = 1'b0;
        rc = 0; cur_wait = 0; fixed_wait = 0; rand_mode = 1'b0;
        n_acks = 0; starve = 0; m_drain = 1'b0; m_addr = '0; m_tgt = '0;

        // Reset state
        repeat (3) cycle();
        chk_reset_outputs("reset");

        // Zero-wait streaming, latency and address wrap
        IR_READY = 1'b1;
        RST = 1'b0;
        cycle();
        chk("lat_c1_valid", 64'(IR_VALID), 64'd0);
        chk("lat_c1_state", 64'(ESTADO), 64'd2);
        chk("lat_c1_addr", 64'(MEM_ADDR), 64'h0000);
        chk("wrap_addr0", 64'(b_MEM_ADDR), 64'hFFFC);
        cycle();
        chk("lat_c2_valid", 64'(IR_VALID), 64'd1);
        chk("stream_ir0", 64'(IR), 64'd0);
        chk("stream_npc0", 64'(NPC), 64'd4);
        chk("wrap_addr1", 64'(b_MEM_ADDR), 64'h0000);
        cycle();
        chk("stream_ir1", 64'(IR), 64'd1);
        chk("stream_npc1", 64'(NPC), 64'd8);
        cycle();
        chk("stream_ir2", 64'(IR), 64'd2);
        chk("stream_npc2", 64'(NPC), 64'd12);
        chk("stream_addr", 64'(MEM_ADDR), 64'd12);

        // Wait states: one instruction every three cycles
        fixed_wait = 2;
        repeat (4) cycle();
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (IR_VALID) vcount++;
            chk("wait_state", 64'(ESTADO), 64'd2);
        end
        chk("wait_valid_pulses", 64'(vcount), 64'd4);

        // Reset in the middle of a fetch
        chk("midrst_pre_state", 64'(ESTADO), 64'd2);
        RST = 1'b1;
        cycle();
        chk_reset_outputs("midrst");

        // Backpressure: queue fills, fetch stops, one pop frees one fetch
        fixed_wait = 0;
        IR_READY   = 1'b0;
        RST        = 1'b0;
        n_acks     = 0;
        repeat (10) cycle();
        chk("bp_pushes", 64'(n_acks), 64'd4);
        chk("bp_req", 64'(MEM_REQ), 64'd0);
        chk("bp_state", 64'(ESTADO), 64'd1);
        IR_READY = 1'b1;
        cycle();
        IR_READY = 1'b0;
        repeat (4) cycle();
        chk("bp_refill", 64'(n_acks), 64'd5);
        chk("bp_state2", 64'(ESTADO), 64'd1);

        // Redirect while a request is waiting
        fixed_wait = 3;
        IR_READY   = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = MEM_REQ && !MEM_ACK;
        end
        chk("rd_wait_found", 64'(found), 64'd1);
        COND = 1'b1; ULA = 16'h0100;
        cycle();
        COND = 1'b0; ULA = '0;
        chk("rd_valid", 64'(IR_VALID), 64'd0);
        chk("rd_state", 64'(ESTADO), 64'd3);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = MEM_REQ && (MEM_ADDR == 16'h0100);
        end
        chk("rd_new_addr", 64'(found), 64'd1);
        chk("rd_new_state", 64'(ESTADO), 64'd2);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = IR_VALID;
        end
        chk("rd_first_valid", 64'(found), 64'd1);
        chk("rd_first_npc", 64'(NPC), 64'h0104);

        // Redirect coincident with ACK and pop
        fixed_wait = 0;
        found      = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = IR_VALID && MEM_ACK && MEM_REQ;
        end
        chk("co_pre", 64'(found), 64'd1);
        COND = 1'b1; ULA = 16'h0200;
        cycle();
        COND = 1'b0; ULA = '0;
        chk("co_valid", 64'(IR_VALID), 64'd0);
        chk("co_addr", 64'(MEM_ADDR), 64'h0200);
        chk("co_req", 64'(MEM_REQ), 64'd1);
        chk("co_state", 64'(ESTADO), 64'd2);

        // Randomized traffic against the model
        rand_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            IR_READY = ($urandom_range(0, 3) != 0);
            COND     = ($urandom_range(0, 15) == 0);
            ULA      = 16'($urandom) & 16'hFFFC;
            RST      = ($urandom_range(0, 299) == 0);
            cycle();
        end
        COND = 1'b0;
        RST  = 1'b0;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
